dmem_arbiter: RTL and testbench

Shares one single-port synchronous data memory (1-cycle read latency) between `NCORES` processor cores in the multi-core build. Each core's data-memory request (`Mem_Ctrl`, `DAddress`, `Ddout`) is arbitrated round-robin and executed as a sequenced memory transaction. The granted core is answered with a one-cycle `acq` pulse plus read data on `Ddin`. The block sits between the core array and the data RAM, replacing the direct core-to-RAM wiring of the single-core build.

---
 rtl/dmem_arbiter_pkg.sv | 10 +
 rtl/dmem_arbiter_rr_pick.sv | 22 ++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: memory request codes and arbiter FSM encoding shared by the core array and the data-memory arbiter.
package dmem_arbiter_pkg;
    localparam logic [3:0] MC_IDLE  = 4'b0000;
    localparam logic [3:0] MC_READ  = 4'b0001;
    localparam logic [3:0] MC_WRITE = 4'b0010;
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;
    function automatic logic is_req(input logic [3:0] code);
        return code == MC_READ || code == MC_WRITE;
    endfunction
endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr and wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);
    logic [PW-1:0] j;
    // Scan offsets from farthest to nearest so the nearest requester overwrites idx last.
    always_comb begin
        valid = |req;
        idx = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % N);
            idx = req[j] ? j : idx;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port synchronous data RAM between NCORES cores.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int AW = 8,
    parameter int DW = 8,
    localparam int GW = $clog2(NCORES)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [4*NCORES-1:0]  core_ctrl,
    input  logic [AW*NCORES-1:0] core_addr,
    input  logic [DW*NCORES-1:0] core_wdata,
    output logic [DW-1:0]        core_rdata,
    output logic [NCORES-1:0]    core_acq,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [DW-1:0]        mem_rdata,
    output logic [GW-1:0]        gnt_id
);
    state_t state_q, state_d;
    logic [3:0] ctrl [NCORES];
    logic [AW-1:0] addr [NCORES];
    logic [DW-1:0] wdata [NCORES];
    logic [NCORES-1:0] req;
    logic pick_valid, grant;
    logic [GW-1:0] pick_idx, ptr_q, ptr_d, gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic wr_q, wr_d, re_q, re_d, we_q, we_d;
    logic [NCORES-1:0] acq_q, acq_d;

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            ctrl[i] = core_ctrl[4*i +: 4];
            addr[i] = core_addr[AW*i +: AW];
            wdata[i] = core_wdata[DW*i +: DW];
            req[i] = is_req(ctrl[i]);
        end
    end

    rr_pick #(.N(NCORES), .PW(GW)) u_pick (
        .req(req),
        .ptr(ptr_q),
        .valid(pick_valid),
        .idx(pick_idx)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick_valid ? ACCESS : IDLE;
            ACCESS:  state_d = wr_q ? ACK : CAPTURE;
            CAPTURE: state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and acq are computed one state early so they leave the block registered.
    always_comb begin
        grant = state_q == IDLE && pick_valid;
        ptr_d = grant ? GW'((int'(pick_idx) + 1) % NCORES) : ptr_q;
        gnt_d = grant ? pick_idx : gnt_q;
        addr_d = grant ? addr[pick_idx] : addr_q;
        wdata_d = grant ? wdata[pick_idx] : wdata_q;
        wr_d = grant ? ctrl[pick_idx] == MC_WRITE : wr_q;
        re_d = grant && ctrl[pick_idx] == MC_READ;
        we_d = grant && ctrl[pick_idx] == MC_WRITE;
        rdata_d = state_q == CAPTURE ? mem_rdata : rdata_q;
        acq_d = state_d == ACK ? NCORES'(1) << gnt_q : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr_q <= '0;
            gnt_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            wr_q <= 1'b0;
            re_q <= 1'b0;
            we_q <= 1'b0;
            rdata_q <= '0;
            acq_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wr_q <= wr_d;
            re_q <= re_d;
            we_q <= we_d;
            rdata_q <= rdata_d;
            acq_q <= acq_d;
        end
    end

    assign core_rdata = rdata_q;
    assign core_acq = acq_q;
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re = re_q;
    assign mem_we = we_q;
    assign gnt_id = gnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_dmem_arbiter;
    localparam int N = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam logic [3:0] RD = 4'b0001;
    localparam logic [3:0] WR = 4'b0010;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic [4*N-1:0] core_ctrl = '0;
    logic [AW*N-1:0] core_addr = '0;
    logic [DW*N-1:0] core_wdata = '0;
    logic [DW-1:0] core_rdata, mem_wdata, mem_rdata;
    logic [N-1:0] core_acq;
    logic [AW-1:0] mem_addr;
    logic mem_we, mem_re;
    logic [1:0] gnt_id;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    dmem_arbiter #(.NCORES(N), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .core_ctrl(core_ctrl), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_acq(core_acq),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .gnt_id(gnt_id)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h85;
    endfunction

    // RAM: unwritten locations hold init_val(addr), so RAM[0x20] = 0xA5.
    bit [7:0] ram [256];
    bit ram_w [256];
    always @(posedge CLK) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            ram_w[mem_addr] <= 1'b1;
        end
        if (mem_re) mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, described by grant age since the grant edge.
    bit m_live, m_busy, m_rd;
    int m_age, m_ptr, m_gnt;
    logic [7:0] m_addr, m_wdata, m_rdata, m_pend;
    bit [7:0] m_mem [256];
    bit m_w [256];

    task automatic model_step();
        int c;
        bit found;
        logic [3:0] op;
        if (!RST_N) begin
            m_live = 1; m_busy = 0; m_age = 0; m_ptr = 0; m_gnt = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0;
        end else if (m_busy) begin
            m_age++;
            if (m_rd && m_age == 3) m_rdata = m_pend;
            if (m_age == (m_rd ? 4 : 3)) m_busy = 0;
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                op = core_ctrl[4*c +: 4];
                if (!found && (op == RD || op == WR)) begin
                    found = 1;
                    m_busy = 1; m_age = 1; m_gnt = c; m_ptr = (c + 1) % N;
                    m_rd = op == RD;
                    m_addr = core_addr[8*c +: 8];
                    m_wdata = core_wdata[8*c +: 8];
                    if (m_rd) m_pend = m_w[m_addr] ? m_mem[m_addr] : init_val(m_addr);
                    else begin
                        m_mem[m_addr] = m_wdata;
                        m_w[m_addr] = 1;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        model_step();
        if (m_live) begin
            chk("mem_re", 32'(mem_re), 32'(m_busy && m_age == 1 && m_rd));
            chk("mem_we", 32'(mem_we), 32'(m_busy && m_age == 1 && !m_rd));
            chk("core_acq", 32'(core_acq), (m_busy && m_age == (m_rd ? 3 : 2)) ? 32'(1) << m_gnt : 32'(0));
            chk("core_rdata", 32'(core_rdata), 32'(m_rdata));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
        end
    end

    task automatic set_req(input int c, input logic [3:0] op, input logic [7:0] a, input logic [7:0] d);
        core_ctrl[4*c +: 4] = op;
        core_addr[8*c +: 8] = a;
        core_wdata[8*c +: 8] = d;
    endtask

    // Waits (bounded) for an acq pulse; optionally drops the served core's request like a real core.
    task automatic wait_acq(output int at, output logic [N-1:0] who, input bit drop);
        who = '0;
        at = -1;
        for (int i = 0; i < 20 && who == '0; i++) begin
            @(negedge CLK);
            if (core_acq != '0) begin
                who = core_acq;
                at = cyc;
            end
        end
        if (who == '0) begin
            checks++;
            errors++;
            $display("FAIL acq_timeout: got no acq expected a pulse within 20 cycles (cycle %0d)", cyc);
        end
        for (int c = 0; c < N; c++) if (drop && who[c]) core_ctrl[4*c +: 4] = 4'b0000;
    endtask

    initial begin
        int t, at, prev, n_acq;
        logic [N-1:0] who;
        logic [7:0] exp_d;
        repeat (3) @(negedge CLK);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_acq", 32'(core_acq), 0);
        chk("rst_rdata", 32'(core_rdata), 0);
        chk("rst_gnt", 32'(gnt_id), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        RST_N = 1'b1;
        // single read from core 1
        @(negedge CLK);
        t = cyc;
        set_req(1, RD, 8'h20, 8'h00);
        @(negedge CLK);
        chk("rd_re", 32'(mem_re), 1);
        chk("rd_addr", 32'(mem_addr), 32'h20);
        wait_acq(at, who, 1);
        chk("rd_latency", 32'(at - t), 3);
        chk("rd_acq", 32'(who), 32'b0010);
        chk("rd_data", 32'(core_rdata), 32'hA5);
        // single write from core 2, then read back by core 0
        @(negedge CLK);
        t = cyc;
        set_req(2, WR, 8'h10, 8'h3C);
        @(negedge CLK);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 32'h10);
        chk("wr_wdata", 32'(mem_wdata), 32'h3C);
        wait_acq(at, who, 1);
        chk("wr_latency", 32'(at - t), 2);
        chk("wr_acq", 32'(who), 32'b0100);
        chk("wr_rdata_hold", 32'(core_rdata), 32'hA5);
        set_req(0, RD, 8'h10, 8'h00);
        wait_acq(at, who, 1);
        chk("rb_acq", 32'(who), 32'b0001);
        chk("rb_data", 32'(core_rdata), 32'h3C);
        // fairness: all cores read continuously from reset
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < N; c++) set_req(c, RD, 8'(8'h40 + c), 8'h00);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_acq(at, who, 0);
            exp_d = init_val(8'(8'h40 + k % N));
            chk("fair_order", 32'(who), 32'(1) << (k % N));
            chk("fair_data", 32'(core_rdata), 32'(exp_d));
            if (k > 0) chk("fair_gap", 32'(at - prev), 4);
            prev = at;
        end
        core_ctrl = '0;
        // pointer wrap: grant core 2 to move the pointer to 3, then cores 0 and 3 compete
        set_req(2, RD, 8'h02, 8'h00);
        wait_acq(at, who, 1);
        chk("wrap_pre", 32'(who), 32'b0100);
        set_req(0, RD, 8'h01, 8'h00);
        set_req(3, WR, 8'h33, 8'h77);
        wait_acq(at, who, 1);
        chk("wrap_first", 32'(who), 32'b1000);
        wait_acq(at, who, 1);
        chk("wrap_second", 32'(who), 32'b0001);
        set_req(0, RD, 8'h33, 8'h00);
        set_req(1, RD, 8'h34, 8'h00);
        wait_acq(at, who, 1);
        chk("wrap_ptr1", 32'(who), 32'b0010);
        wait_acq(at, who, 1);
        chk("wrap_ptr1_next", 32'(who), 32'b0001);
        chk("wrap_rdata", 32'(core_rdata), 32'h77);
        // illegal code from core 0 is never served
        set_req(0, 4'b0011, 8'h21, 8'h00);
        set_req(1, RD, 8'h22, 8'h00);
        wait_acq(at, who, 1);
        chk("illegal_served", 32'(who), 32'b0010);
        n_acq = 0;
        repeat (10) begin
            @(negedge CLK);
            if (core_acq != '0 || mem_re || mem_we) n_acq++;
        end
        chk("illegal_ignored", 32'(n_acq), 0);
        core_ctrl = '0;
        // reset during CAPTURE aborts the read
        @(negedge CLK);
        set_req(1, RD, 8'h30, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        set_req(1, 4'b0000, 8'h00, 8'h00);
        @(negedge CLK);
        chk("mrst_acq", 32'(core_acq), 0);
        chk("mrst_rdata", 32'(core_rdata), 0);
        chk("mrst_gnt", 32'(gnt_id), 0);
        chk("mrst_re", 32'(mem_re), 0);
        RST_N = 1'b1;
        set_req(0, RD, 8'h05, 8'h00);
        set_req(2, RD, 8'h06, 8'h00);
        wait_acq(at, who, 1);
        chk("mrst_ptr0", 32'(who), 32'b0001);
        wait_acq(at, who, 1);
        chk("mrst_next", 32'(who), 32'b0100);
        core_ctrl = '0;
        repeat (5) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1);
    end
endmodule
